// File: rtl/regfile_mp.sv
// regfile_mp -- multi-ported register file with a per-register busy
// scoreboard.
//
// Purpose:
//   The file holds 2**ADDR_W registers of DATA_W bits. It has two write
//   ports and NUM_RD combinational read ports. Register 0 is hard-wired
//   to zero and is never busy.
//   Each register has a busy bit that marks a pending producer:
//     - busy_set_* sets the bit.
//     - A write with wr_clr clears the bit.
//     - If a set and a clear hit the same register in one cycle, the set
//       wins, because the new producer is the one still outstanding.
//
// Build option:
//   REGFILE_BYPASS_EN   When defined, a read returns the data and busy
//                       state of a same-cycle write to the same register.
//                       Write port 1 has priority over write port 0.
//                       When undefined, reads return stored state only.
//
// Ports:
//   clk, rst_n     Clock (rising edge). Reset is asynchronous and
//                  active-low.
//   we[1:0]        Write enable for each write port.
//   wr_addr        Write address. Port p uses [p*ADDR_W +: ADDR_W].
//   wr_data        Write data. Port p uses [p*DATA_W +: DATA_W].
//   wr_clr[1:0]    An enabled write also clears busy[wr_addr].
//   busy_set_en    Mark busy_set_addr as pending.
//   busy_set_addr  Register to mark as pending.
//   rd_en          Read enable for each read port.
//   rd_addr        Read address. Port r uses [r*ADDR_W +: ADDR_W].
//   rd_data        Read data. Port r uses [r*DATA_W +: DATA_W].
//                  It is zero when the port is disabled or reads r0.
//   rd_busy        Busy flag of the addressed register. It is zero when
//                  the port is disabled or reads r0.
//   wr_conflict    Registered pulse. It is high when, in the previous
//                  cycle, both write ports were enabled to the same
//                  non-zero address.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 we,
  input  logic [2*ADDR_W-1:0]        wr_addr,
  input  logic [2*DATA_W-1:0]        wr_data,
  input  logic [1:0]                 wr_clr,
  input  logic                       busy_set_en,
  input  logic [ADDR_W-1:0]          busy_set_addr,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Unpacked views of the two write ports.
  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [1:0]        wv;   // write enabled and aimed at a real register
  logic              set_v;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wa[p] = wr_addr[p*ADDR_W +: ADDR_W];
      wd[p] = wr_data[p*DATA_W +: DATA_W];
      wv[p] = we[p] && (wa[p] != '0);
    end
    set_v = busy_set_en && (busy_set_addr != '0);
  end

  // Storage. Index 0 is excluded from updates, so r0 stays at its reset
  // value of zero. Port 1 is tested first, so it wins a same-address
  // collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wv[1] && (wa[1] == ADDR_W'(i)))      regs[i] <= wd[1];
        else if (wv[0] && (wa[0] == ADDR_W'(i))) regs[i] <= wd[0];
      end
    end
  end

  // Busy scoreboard. The clear is applied before the set, so a
  // same-cycle set of the same register leaves the bit high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if ((we[0] && wr_clr[0] && (wa[0] == ADDR_W'(i))) ||
            (we[1] && wr_clr[1] && (wa[1] == ADDR_W'(i))))
          busy[i] <= 1'b0;
        if (set_v && (busy_set_addr == ADDR_W'(i)))
          busy[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_conflict <= 1'b0;
    else        wr_conflict <= wv[0] && wv[1] && (wa[0] == wa[1]);
  end

  // Combinational read ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;
      a = rd_addr[r*ADDR_W +: ADDR_W];
      d = '0;
      b = 1'b0;
      if (rd_en[r] && (a != '0)) begin
        d = regs[a];
        b = busy[a];
`ifdef REGFILE_BYPASS_EN
        // The bypass is blocked while in reset, so reads stay zero
        // regardless of the write inputs. Port 0 is checked first and
        // port 1 overrides it.
        if (rst_n) begin
          for (int p = 0; p < 2; p++) begin
            if (wv[p] && (wa[p] == a)) begin
              d = wd[p];
              if (wr_clr[p] && !(set_v && (busy_set_addr == a))) b = 1'b0;
              else                                                b = busy[a];
            end
          end
        end
`endif
      end
      rd_data[r*DATA_W +: DATA_W] = d;
      rd_busy[r] = b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp.
//
// Instances:
//   dut    Default parameters: 32-bit data, 32 registers, 4 read ports.
//   dut_s  Reduced configuration: 16-bit data, 8 registers, 2 read ports.
//
// Reference model: a register array and a busy array. Both are updated
// once per rising edge from the inputs applied during that cycle.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              clk;
  logic              rst_n;
  logic [1:0]        we;
  logic [2*AW-1:0]   wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic [1:0]        wr_clr;
  logic              busy_set_en;
  logic [AW-1:0]     busy_set_addr;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_conflict;

  // Reduced-parameter instance signals.
  logic [1:0]  s_we;
  logic [5:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [1:0]  s_wr_clr;
  logic        s_busy_set_en;
  logic [2:0]  s_busy_set_addr;
  logic [1:0]  s_rd_en;
  logic [5:0]  s_rd_addr;
  logic [31:0] s_rd_data;
  logic [1:0]  s_rd_busy;
  logic        s_wr_conflict;

  int n_checks;
  int n_fail;

  // Reference model state.
  logic [DW-1:0] m_regs [32];
  logic          m_busy [32];
  logic          m_conflict;

  logic [DW-1:0] exp_q  [$];
  logic          bexp_q [$];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_clr(wr_clr), .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_conflict(wr_conflict)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .we(s_we), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_clr(s_wr_clr), .busy_set_en(s_busy_set_en), .busy_set_addr(s_busy_set_addr),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_conflict(s_wr_conflict)
  );

  // ---------------------------------------------------------------------
  // Clock and reset helpers
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_conflict = 1'b0;
  endtask

  // Apply the rules for one rising edge to the reference model.
  task automatic model_commit();
    logic [AW-1:0] a0, a1;
    a0 = wr_addr[AW-1:0];
    a1 = wr_addr[2*AW-1:AW];
    m_conflict = we[0] && we[1] && (a0 == a1) && (a0 != 0);
    if (we[0] && a0 != 0) m_regs[a0] = wr_data[DW-1:0];
    if (we[1] && a1 != 0) m_regs[a1] = wr_data[2*DW-1:DW];
    if (we[0] && wr_clr[0]) m_busy[a0] = 1'b0;
    if (we[1] && wr_clr[1]) m_busy[a1] = 1'b0;
    if (busy_set_en) m_busy[busy_set_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  // One clock: commit at the rising edge, then return 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_commit();
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic set_idle();
    we = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic s_set_idle();
    s_we = '0; s_wr_addr = '0; s_wr_data = '0; s_wr_clr = '0;
    s_busy_set_en = 1'b0; s_busy_set_addr = '0;
    s_rd_en = '0; s_rd_addr = '0;
  endtask

  task automatic read_all(input logic [AW-1:0] a);
    rd_en = '1;
    for (int r = 0; r < NR; r++) rd_addr[r*AW +: AW] = a;
  endtask

  // Expected read values, derived from the model and the applied inputs.
  function automatic logic [DW-1:0] exp_data(input int r);
    logic [AW-1:0] a;
    a = rd_addr[r*AW +: AW];
    if (!rd_en[r] || a == 0 || !rst_n) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we[1] && wr_addr[2*AW-1:AW] == a) return wr_data[2*DW-1:DW];
    if (we[0] && wr_addr[AW-1:0] == a)    return wr_data[DW-1:0];
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int r);
    logic [AW-1:0] a;
    logic          set_hit;
    a = rd_addr[r*AW +: AW];
    if (!rd_en[r] || a == 0 || !rst_n) return 1'b0;
    set_hit = busy_set_en && (busy_set_addr == a);
`ifdef REGFILE_BYPASS_EN
    if (we[1] && wr_addr[2*AW-1:AW] == a) return (wr_clr[1] && !set_hit) ? 1'b0 : m_busy[a];
    if (we[0] && wr_addr[AW-1:0] == a)    return (wr_clr[0] && !set_hit) ? 1'b0 : m_busy[a];
`endif
    return m_busy[a];
  endfunction

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    // In reset with random live inputs, all outputs must read zero.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      we = 2'($urandom_range(0, 3)); wr_addr = 10'($urandom); wr_data = {$urandom, $urandom};
      wr_clr = 2'($urandom_range(0, 3)); busy_set_en = 1'b1; busy_set_addr = 5'($urandom_range(1, 31));
      rd_en = '1; rd_addr = 20'($urandom);
      step();
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0 || wr_conflict !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: rd_data=%h rd_busy=%b wr_conflict=%b, required all zero",
                 rd_data, rd_busy, wr_conflict);
      end
    end
    set_idle();
    #3 rst_n = 1'b1;
    step();
    // Write r5, confirm it, then assert reset in mid-cycle.
    we = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    step();
    set_idle();
    read_all(5'd5);
    #1;
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL r5_before_reset: got %h, required deadbeef", rd_data[DW-1:0]);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL r5_async_reset: got %h, required 0", rd_data);
    end
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL r5_after_release: got %h, required 0", rd_data[DW-1:0]);
    end
    set_idle();
  endtask

  task automatic test_conflict();
    we = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
    step();
    set_idle();
    read_all(5'd7);
    #1;
    n_checks++;
    if (wr_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_pulse: got %b, required 1", wr_conflict);
    end
    n_checks++;
    if (rd_data[2*DW-1:DW] !== 32'h22222222) begin
      n_fail++;
      $display("FAIL conflict_winner: got %h, required 22222222", rd_data[2*DW-1:DW]);
    end
    step();
    n_checks++;
    if (wr_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_one_cycle: got %b, required 0", wr_conflict);
    end
    // Writes to r0 on both ports must not raise a conflict.
    we = 2'b11; wr_addr = '0; wr_data = '1;
    step();
    set_idle();
    n_checks++;
    if (wr_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_r0: got %b, required 0", wr_conflict);
    end
  endtask

  task automatic test_zero_reg();
    we = 2'b01; wr_addr = '0; wr_data = {32'd0, 32'hFFFFFFFF};
    busy_set_en = 1'b1; busy_set_addr = '0;
    step();
    set_idle();
    read_all(5'd0);
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL zero_reg: rd_data=%h rd_busy=%b, required 0", rd_data, rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    step();
    set_idle();
    read_all(5'd9);
    #1;
    n_checks++;
    if (rd_busy !== '1) begin
      n_fail++;
      $display("FAIL busy_set: got %b, required 1111", rd_busy);
    end
    we = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h1234}; wr_clr = 2'b01;
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    step();
    set_idle();
    read_all(5'd9);
    #1;
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h1234 || rd_busy !== '1) begin
      n_fail++;
      $display("FAIL set_beats_clear: data=%h busy=%b, required 00001234 / 1111",
               rd_data[DW-1:0], rd_busy);
    end
    // A write without wr_clr leaves the bit set. A write with wr_clr
    // clears it.
    we = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h55, 32'd0}; wr_clr = 2'b00;
    step();
    set_idle();
    read_all(5'd9);
    #1;
    n_checks++;
    if (rd_busy !== '1) begin
      n_fail++;
      $display("FAIL no_clr_keeps_busy: got %b, required 1111", rd_busy);
    end
    we = 2'b10; wr_addr = {5'd9, 5'd0}; wr_clr = 2'b10;
    step();
    set_idle();
    read_all(5'd9);
    #1;
    n_checks++;
    if (rd_busy !== '0) begin
      n_fail++;
      $display("FAIL clr_clears_busy: got %b, required 0000", rd_busy);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want_d;
    logic [NR-1:0] want_b;
    we = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h0BAD0BAD};
    busy_set_en = 1'b1; busy_set_addr = 5'd3;
    step();
    set_idle();
    we = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hCAFEF00D}; wr_clr = 2'b01;
    read_all(5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    want_d = 32'hCAFEF00D; want_b = '0;
`else
    want_d = 32'h0BAD0BAD; want_b = '1;
`endif
    for (int r = 0; r < NR; r++) begin
      n_checks++;
      if (rd_data[r*DW +: DW] !== want_d) begin
        n_fail++;
        $display("FAIL bypass_data port %0d: got %h, required %h", r, rd_data[r*DW +: DW], want_d);
      end
    end
    n_checks++;
    if (rd_busy !== want_b) begin
      n_fail++;
      $display("FAIL bypass_busy: got %b, required %b", rd_busy, want_b);
    end
    step();
    set_idle();
    read_all(5'd3);
    #1;
    n_checks++;
    if (rd_data[3*DW +: DW] !== 32'hCAFEF00D || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: data=%h busy=%b, required cafef00d / 0000",
               rd_data[3*DW +: DW], rd_busy);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      we = 2'($urandom_range(0, 3));
      wr_clr = 2'($urandom_range(0, 3));
      busy_set_en = 1'($urandom_range(0, 1));
      busy_set_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) begin
        wr_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wr_data[p*DW +: DW] = $urandom;
      end
      rd_en = 4'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++)
        rd_addr[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      for (int r = 0; r < NR; r++) begin
        exp_q.push_back(exp_data(r));
        bexp_q.push_back(exp_busy(r));
      end
      for (int r = 0; r < NR; r++) begin
        logic [DW-1:0] ed;
        logic          eb;
        ed = exp_q.pop_front();
        eb = bexp_q.pop_front();
        n_checks++;
        if (rd_data[r*DW +: DW] !== ed || rd_busy[r] !== eb) begin
          n_fail++;
          $display("FAIL random_read cyc %0d port %0d addr %0d: data=%h busy=%b, required %h / %b",
                   cyc, r, rd_addr[r*AW +: AW], rd_data[r*DW +: DW], rd_busy[r], ed, eb);
        end
      end
      step();
      n_checks++;
      if (wr_conflict !== m_conflict) begin
        n_fail++;
        $display("FAIL random_conflict cyc %0d: got %b, required %b", cyc, wr_conflict, m_conflict);
      end
    end
    set_idle();
  endtask

  task automatic test_param_sweep();
    s_we = 2'b10; s_wr_addr = {3'd7, 3'd0}; s_wr_data = {16'hA5A5, 16'h0000};
    step();
    s_set_idle();
    s_rd_en = 2'b11; s_rd_addr = {3'd7, 3'd7};
    #1;
    n_checks++;
    if (s_rd_data !== 32'hA5A5A5A5 || s_rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL sweep_r7: data=%h busy=%b, required a5a5a5a5 / 00", s_rd_data, s_rd_busy);
    end
    s_rd_addr = {3'd6, 3'd0};
    #1;
    n_checks++;
    if (s_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL sweep_other: got %h, required 0", s_rd_data);
    end
    s_set_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    set_idle();
    s_set_idle();
    model_clear();
    test_reset();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
